// File: rtl/fib_req_driver.sv
// Batch initiator for the fib core: issues one strobe per index, waits for the core
// to finish, and queues each result in a first-word-fall-through FIFO.
module fib_req_driver #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_first_n,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_fib_stb,
   output logic [WIDTH-1:0] o_fib_n,
   input  logic             i_fib_busy,
   input  logic [WIDTH-1:0] i_fib_result,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [LW-1:0]    o_level
);

   typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

   state_t           state;
   logic [WIDTH-1:0] n;
   logic [CNT_W-1:0] remaining;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    level;
   logic             push, pop, can_issue;

   // A strobe is only issued when the FIFO has room, so the later push can never overflow.
   assign can_issue = (state == ISSUE) && !i_fib_busy && (level < LW'(DEPTH));
   assign push      = (state == WAIT) && !i_fib_busy;
   assign pop       = (level != '0) && i_ready;

   assign o_fib_stb = can_issue;
   assign o_fib_n   = n;
   assign o_busy    = (state != IDLE);
   assign o_valid   = (level != '0);
   assign o_data    = o_valid ? mem[rd_ptr] : '0;
   assign o_level   = level;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         n         <= '0;
         remaining <= '0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (i_count != '0) begin
                     n         <= i_first_n;
                     remaining <= i_count;
                     state     <= ISSUE;
                  end else begin
                     o_done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (can_issue) state <= SETTLE;
            end
            // Core busy lags the strobe by a cycle, so it is not trusted here.
            SETTLE: state <= WAIT;
            WAIT: begin
               if (!i_fib_busy) begin
                  n         <= n + WIDTH'(1);
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state  <= IDLE;
                     o_done <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_fib_result;
   end

endmodule

// File: tb/tb_fib_req_driver.sv
// Scoreboard bench for fib_req_driver driving a stub core (busy k cycles, result k+100).
module tb_fib_req_driver;
   localparam int W = 8;
   localparam int D = 4;
   localparam int C = 8;
   localparam int LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  first_n = '0;
   logic [C-1:0]  count = '0;
   logic          busy, done, stb, valid;
   logic          ready = 1'b1;
   logic [W-1:0]  fib_n, data;
   logic [LW-1:0] level;
   logic          sbusy = 1'b0;
   logic [W-1:0]  sres = '0;
   logic [W-1:0]  scnt = '0;

   always #5 clk = ~clk;

   fib_req_driver #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_first_n(first_n), .i_count(count),
      .o_busy(busy), .o_done(done), .o_fib_stb(stb), .o_fib_n(fib_n),
      .i_fib_busy(sbusy), .i_fib_result(sres),
      .o_data(data), .o_valid(valid), .i_ready(ready), .o_level(level)
   );

   // Stub core; deliberately not reset with the driver.
   always @(posedge clk) begin
      if (!sbusy) begin
         if (stb) begin
            sres <= fib_n + W'(100);
            if (fib_n != '0) begin
               sbusy <= 1'b1;
               scnt  <= fib_n;
            end
         end
      end else begin
         scnt <= scnt - W'(1);
         if (scnt == W'(1)) sbusy <= 1'b0;
      end
   end

   int checks = 0, failures = 0;
   int strobes = 0, dones = 0, pops = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] n_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (stb) begin
            strobes++;
            if (n_q.size() != 0) chk("stb_n", 32'(fib_n), 32'(n_q.pop_front()));
            else chk("stb_extra", 32'(n_q.size()), 32'd1);
         end
         if (valid && ready) begin
            pops++;
            if (exp_q.size() != 0) chk("data", 32'(data), 32'(exp_q.pop_front()));
            else chk("data_extra", 32'(exp_q.size()), 32'd1);
         end
         if (done) dones++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] f, input logic [C-1:0] c);
      for (int i = 0; i < int'(c); i++) begin
         logic [W-1:0] k;
         k = f + W'(i);
         n_q.push_back(k);
         exp_q.push_back(k + W'(100));
      end
      first_n = f;
      count   = c;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         tick();
         if (done) break;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   initial begin
      int base;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      rst = 1'b0;
      tick();

      // single index
      do_start(8'd3, 8'd1);
      chk("t1_stb", 32'(stb), 32'd1);
      chk("t1_n", 32'(fib_n), 32'd3);
      wait_done("t1_done", 50);
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_data", 32'(data), 32'd103);
      chk("t1_busy", 32'(busy), 32'd0);
      repeat (3) tick();

      // index 0 never raises core busy
      do_start(8'd0, 8'd2);
      tick(); tick(); tick();
      chk("t2_n0_lat", 32'(valid), 32'd1);
      wait_done("t2_done", 50);
      repeat (3) tick();

      // FIFO full backpressure
      ready = 1'b0;
      do_start(8'd5, 8'd6);
      for (int i = 0; i < 200 && level != LW'(4); i++) tick();
      chk("t3_full", 32'(level), 32'd4);
      base = strobes;
      repeat (20) tick();
      chk("t3_nostb", 32'(strobes - base), 32'd0);
      chk("t3_hold", 32'(busy), 32'd1);
      base = dones;
      ready = 1'b1;
      wait_done("t3_done", 300);
      for (int i = 0; i < 20 && valid; i++) tick();
      repeat (5) tick();
      chk("t3_drain", 32'(exp_q.size()), 32'd0);
      chk("t3_one_done", 32'(dones - base), 32'd1);

      // empty batch
      do_start(8'd7, 8'd0);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_stb", 32'(stb), 32'd0);
      tick();
      chk("t4_pulse", 32'(done), 32'd0);
      chk("t4_valid", 32'(valid), 32'd0);
      repeat (3) tick();

      // reset during second index WAIT
      base = strobes;
      do_start(8'd4, 8'd3);
      for (int i = 0; i < 100 && strobes < base + 2; i++) tick();
      chk("t5_second", 32'(strobes - base), 32'd2);
      tick();
      rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_level", 32'(level), 32'd0);
      chk("t5_valid", 32'(valid), 32'd0);
      chk("t5_data", 32'(data), 32'd0);
      chk("t5_fib_n", 32'(fib_n), 32'd0);
      exp_q.delete();
      n_q.delete();
      base = dones;
      tick();
      rst = 1'b0;
      tick();
      chk("t5_no_done", 32'(dones - base), 32'd0);
      do_start(8'd1, 8'd1);
      wait_done("t5_restart", 50);
      repeat (3) tick();
      chk("t5_drain", 32'(exp_q.size()), 32'd0);

      // index wrap
      do_start(8'd255, 8'd2);
      wait_done("t6_done", 400);
      repeat (3) tick();
      chk("t6_drain", 32'(exp_q.size()), 32'd0);

      // start mid-batch is ignored
      base = pops;
      do_start(8'd10, 8'd3);
      repeat (5) tick();
      first_n = 8'd50;
      count   = 8'd5;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      wait_done("t7_done", 400);
      repeat (10) tick();
      chk("t7_count", 32'(pops - base), 32'd3);
      chk("t7_drain", 32'(exp_q.size()), 32'd0);
      chk("total_dones", 32'(dones), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
